// File: rtl/display_mode_ctrl.sv
// Display mode sequencer for the bike computer: short press advances the mode on release,
// long press clears the trip, optional idle auto-scroll, and overspeed lamp blinking.
module display_mode_ctrl #(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned SPEED_WIDTH     = 7,
  parameter int unsigned OVERSPEED       = 65,
  parameter int unsigned STOP_SPEED      = 6,
  parameter int unsigned LONG_PRESS_SEC  = 2,
  parameter int unsigned AUTO_SCROLL_SEC = 4,
  localparam int unsigned MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode_pulse,
  input  logic                   mode_level,
  input  logic                   half_sec_pulse,
  input  logic                   sec_pulse,
  input  logic [SPEED_WIDTH-1:0] speed,
  input  logic                   speed_valid,
  input  logic                   auto_scroll_en,
  output logic [MODE_W-1:0]      mode_sel,
  output logic [NUM_MODES-1:0]   lamps,
  output logic                   refresh,
  output logic                   col,
  output logic                   clear_trip,
  output logic                   en_trip
);
  localparam int unsigned IDLE_W = (AUTO_SCROLL_SEC > 2) ? $clog2(AUTO_SCROLL_SEC) : 1;
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_TIM  = MODE_W'(2);
  localparam logic [3:0]        HOLD_LAST = 4'(LONG_PRESS_SEC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((AUTO_SCROLL_SEC == 0) ? 0 : AUTO_SCROLL_SEC - 1);
  localparam bit AUTO_ON = (AUTO_SCROLL_SEC != 0);
  localparam bit HAS_TIM = (NUM_MODES > 2);

  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  state_e                 r_state, w_state_next;
  logic [3:0]             r_hold_cnt, w_hold_next;
  logic [IDLE_W-1:0]      r_idle_cnt, w_idle_next;
  logic [MODE_W-1:0]      r_mode_sel, w_mode_inc;
  logic [SPEED_WIDTH-1:0] r_speed;
  logic [NUM_MODES-1:0]   r_lamps, w_lamps_next;
  logic r_blink, r_refresh, r_col, r_clear_trip, r_en_trip, r_adv_q, r_rst_q;
  logic w_release_adv, w_clear_next, w_auto_adv, w_adv, w_overblink, w_col_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold_cnt;
    w_release_adv = 1'b0;
    w_clear_next  = 1'b0;
    case (r_state)
      StIdle: begin
        if (mode_pulse) begin
          w_state_next = StPressed;
          w_hold_next  = '0;
        end
      end
      StPressed: begin
        // Release wins over a coincident sec_pulse; the mode advances on release only.
        if (!mode_level) begin
          w_state_next  = StIdle;
          w_release_adv = 1'b1;
        end else if (sec_pulse) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_next = StLong;
            w_clear_next = 1'b1;
          end else begin
            w_hold_next = r_hold_cnt + 4'd1;
          end
        end
      end
      StLong: begin
        if (!mode_level) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // A button pulse on the terminal idle second cancels the auto-advance.
  assign w_auto_adv = AUTO_ON && (r_state == StIdle) && auto_scroll_en && sec_pulse &&
                      !mode_pulse && (r_idle_cnt == IDLE_LAST);
  assign w_adv      = w_release_adv | w_auto_adv;
  assign w_mode_inc = (r_mode_sel == MODE_LAST) ? '0 : r_mode_sel + MODE_W'(1);

  always_comb begin
    w_idle_next = r_idle_cnt;
    if (!AUTO_ON || !auto_scroll_en || mode_pulse || w_adv) begin
      w_idle_next = '0;
    end else if ((r_state == StIdle) && sec_pulse) begin
      w_idle_next = r_idle_cnt + IDLE_W'(1);
    end
  end

  assign w_overblink  = r_blink && (32'(r_speed) > OVERSPEED);
  assign w_lamps_next = w_overblink ? '1 : (NUM_MODES'(1) << r_mode_sel);
  assign w_col_next   = (HAS_TIM && (r_mode_sel == MODE_TIM)) ? (r_col ^ r_refresh) : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt   <= '0;
      r_mode_sel   <= '0;
      r_speed      <= '0;
      r_blink      <= 1'b0;
      r_lamps      <= '0;
      r_refresh    <= 1'b0;
      r_col        <= 1'b0;
      r_clear_trip <= 1'b0;
      r_en_trip    <= 1'b0;
      r_adv_q      <= 1'b0;
      r_rst_q      <= 1'b1;
    end else begin
      r_idle_cnt <= w_idle_next;
      if (w_adv) r_mode_sel <= w_mode_inc;
      if (speed_valid) r_speed <= speed;
      if (half_sec_pulse) r_blink <= ~r_blink;
      r_lamps      <= w_lamps_next;
      // r_rst_q marks the first cycle out of reset so the display redraws once.
      r_refresh    <= sec_pulse | r_adv_q | r_rst_q;
      r_col        <= w_col_next;
      r_clear_trip <= w_clear_next;
      r_en_trip    <= (32'(r_speed) >= STOP_SPEED);
      r_adv_q      <= w_adv;
      r_rst_q      <= 1'b0;
    end
  end

  assign mode_sel   = r_mode_sel;
  assign lamps      = r_lamps;
  assign refresh    = r_refresh;
  assign col        = r_col;
  assign clear_trip = r_clear_trip;
  assign en_trip    = r_en_trip;

endmodule
